// File: rtl/fwd_scoreboard.sv
// Operand-forwarding scoreboard between ID and EX.
// Tracks in-flight destinations for stages EX..WB, resolves each source
// operand to its youngest producer, and stalls ID when that producer's
// result is not yet available. Also keeps saturating stall/forward counters.
module fwd_scoreboard #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned SELW    = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic                      id_reg_write,
  input  logic [4:0]                id_rd,
  input  logic [SELW-1:0]           id_result_stage,
  input  logic [NUM_SRC*5-1:0]      id_rs_addr,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [NUM_SRC*XLEN-1:0]   id_rs_data,
  input  logic [DEPTH*XLEN-1:0]     stage_result,
  input  logic                      pipe_advance,
  input  logic                      flush,
  input  logic                      clear_counters,
  output logic [NUM_SRC*SELW-1:0]   fwd_sel,
  output logic [NUM_SRC*XLEN-1:0]   fwd_data,
  output logic                      hazard_stall,
  output logic [31:0]               stall_count,
  output logic [31:0]               fwd_count
);

  // Tracker entries; index 0 is EX, DEPTH-1 is WB.
  logic [DEPTH-1:0] valid_q;
  logic [4:0]       rd_q     [DEPTH];
  logic [SELW-1:0]  rstage_q [DEPTH];

  logic [31:0] stall_count_q;
  logic [31:0] fwd_count_q;

  logic [NUM_SRC-1:0] hit;
  logic [NUM_SRC-1:0] not_ready;
  logic [SELW-1:0]    rstage_in;
  logic               issue;
  logic [31:0]        fwd_inc;
  logic [32:0]        fwd_sum;

  // Result stages past WB make no sense; clamp so every entry is ready by WB.
  assign rstage_in = (int'(id_result_stage) > int'(DEPTH) - 1) ? SELW'(DEPTH - 1)
                                                               : id_result_stage;

  // Per-port youngest-producer search and operand mux.
  always_comb begin
    fwd_sel   = '0;
    fwd_data  = id_rs_data;
    hit       = '0;
    not_ready = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        if (!hit[i] && id_rs_used[i] && valid_q[k] &&
            (rd_q[k] == id_rs_addr[5*i +: 5]) && (id_rs_addr[5*i +: 5] != 5'd0)) begin
          hit[i] = 1'b1;
          if (k >= int'(rstage_q[k])) begin
            fwd_sel[SELW*i +: SELW]  = SELW'(k + 1);
            fwd_data[XLEN*i +: XLEN] = stage_result[XLEN*k +: XLEN];
          end else begin
            not_ready[i] = 1'b1;
          end
        end
      end
    end
  end

  // Flush squashes the ID instruction, so it also masks any stall it would cause.
  assign hazard_stall = id_valid & ~flush & (|not_ready);
  assign issue        = id_valid & ~flush & ~hazard_stall;

  // Number of ports served from a pipeline stage this cycle.
  always_comb begin
    fwd_inc = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (fwd_sel[SELW*i +: SELW] != '0) fwd_inc = fwd_inc + 32'd1;
    end
  end

  assign fwd_sum = {1'b0, fwd_count_q} + {1'b0, fwd_inc};

  // Tracker shift register: advances with the pipeline, bubbles on stall/flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        rd_q[k]     <= '0;
        rstage_q[k] <= '0;
      end
    end else if (pipe_advance) begin
      for (int k = 1; k < int'(DEPTH); k++) begin
        valid_q[k]  <= valid_q[k-1];
        rd_q[k]     <= rd_q[k-1];
        rstage_q[k] <= rstage_q[k-1];
      end
      // x0 writes are architecturally void, so they never become producers.
      valid_q[0]  <= issue & id_reg_write & (id_rd != 5'd0);
      rd_q[0]     <= id_rd;
      rstage_q[0] <= rstage_in;
    end
  end

  // Saturating performance counters with synchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
      fwd_count_q   <= '0;
    end else if (clear_counters) begin
      stall_count_q <= '0;
      fwd_count_q   <= '0;
    end else begin
      if (hazard_stall && (stall_count_q != 32'hFFFF_FFFF)) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
      if (issue && pipe_advance) begin
        fwd_count_q <= fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
      end
    end
  end

  assign stall_count = stall_count_q;
  assign fwd_count   = fwd_count_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard (default parameters: 2 ports, depth 3).
module tb_fwd_scoreboard;

  localparam int XLEN = 32;
  localparam int NSRC = 2;
  localparam int DEPTH = 3;
  localparam int SELW = 2;

  localparam logic [31:0] RF0 = 32'hAAAA_0000;
  localparam logic [31:0] RF1 = 32'hBBBB_0001;
  localparam logic [31:0] S0  = 32'h0000_1234;
  localparam logic [31:0] S1  = 32'h0000_5678;
  localparam logic [31:0] S2  = 32'h0000_9ABC;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   id_valid;
  logic                   id_reg_write;
  logic [4:0]             id_rd;
  logic [SELW-1:0]        id_result_stage;
  logic [NSRC*5-1:0]      id_rs_addr;
  logic [NSRC-1:0]        id_rs_used;
  logic [NSRC*XLEN-1:0]   id_rs_data;
  logic [DEPTH*XLEN-1:0]  stage_result;
  logic                   pipe_advance;
  logic                   flush;
  logic                   clear_counters;
  logic [NSRC*SELW-1:0]   fwd_sel;
  logic [NSRC*XLEN-1:0]   fwd_data;
  logic                   hazard_stall;
  logic [31:0]            stall_count;
  logic [31:0]            fwd_count;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic        chk_fwd;
    logic [3:0]  sel;
    logic [63:0] data;
    logic        stall;
  } exp_t;

  exp_t exp_q[$];

  fwd_scoreboard dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_reg_write    (id_reg_write),
    .id_rd           (id_rd),
    .id_result_stage (id_result_stage),
    .id_rs_addr      (id_rs_addr),
    .id_rs_used      (id_rs_used),
    .id_rs_data      (id_rs_data),
    .stage_result    (stage_result),
    .pipe_advance    (pipe_advance),
    .flush           (flush),
    .clear_counters  (clear_counters),
    .fwd_sel         (fwd_sel),
    .fwd_data        (fwd_data),
    .hazard_stall    (hazard_stall),
    .stall_count     (stall_count),
    .fwd_count       (fwd_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] rst, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [1:0] used);
    id_valid        = v;
    id_reg_write    = rw;
    id_rd           = rd;
    id_result_stage = rst;
    id_rs_addr      = {rs1, rs0};
    id_rs_used      = used;
  endtask

  // Expected outputs are queued when stimulus is applied.
  task automatic push_exp(input string tag, input logic chk_fwd, input logic [1:0] s0,
                          input logic [1:0] s1, input logic [31:0] d0, input logic [31:0] d1,
                          input logic st);
    exp_t e;
    e.tag = tag; e.chk_fwd = chk_fwd; e.sel = {s1, s0}; e.data = {d1, d0}; e.stall = st;
    exp_q.push_back(e);
  endtask

  // Pops the oldest expectation and compares it against the settled outputs.
  task automatic compare_exp();
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq({e.tag, "_stall"}, 64'(hazard_stall), 64'(e.stall));
      if (e.chk_fwd) begin
        check_eq({e.tag, "_sel"}, 64'(fwd_sel), 64'(e.sel));
        check_eq({e.tag, "_data"}, fwd_data, e.data);
      end
    end
  endtask

  task automatic step(input string tag, input logic chk_fwd, input logic [1:0] s0,
                      input logic [1:0] s1, input logic [31:0] d0, input logic [31:0] d1,
                      input logic st);
    push_exp(tag, chk_fwd, s0, s1, d0, d1, st);
    #2;
    compare_exp();
    @(negedge clk);
  endtask

  task automatic bubbles(input int n);
    for (int b = 0; b < n; b++) begin
      drive(1'b0, 1'b0, 5'd0, 2'd0, 5'd0, 5'd0, 2'b00);
      step("bubble", 1'b1, 2'd0, 2'd0, RF0, RF1, 1'b0);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    pipe_advance   = 1'b1;
    flush          = 1'b0;
    clear_counters = 1'b0;
    id_rs_data     = {RF1, RF0};
    stage_result   = {S2, S1, S0};
    drive(1'b0, 1'b0, 5'd0, 2'd0, 5'd0, 5'd0, 2'b00);

    // Reset state
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd3, 2'd0, 5'd3, 5'd0, 2'b01);
    push_exp("reset", 1'b1, 2'd0, 2'd0, RF0, RF1, 1'b0);
    #2;
    compare_exp();
    check_eq("reset_stall_cnt", 64'(stall_count), 64'd0);
    check_eq("reset_fwd_cnt", 64'(fwd_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU chain: add x5 then reader of x5
    drive(1'b1, 1'b1, 5'd5, 2'd0, 5'd0, 5'd0, 2'b00);
    step("alu_prod", 1'b1, 2'd0, 2'd0, RF0, RF1, 1'b0);
    drive(1'b1, 1'b1, 5'd8, 2'd0, 5'd5, 5'd0, 2'b01);
    step("alu_fwd", 1'b1, 2'd1, 2'd0, S0, RF1, 1'b0);
    bubbles(3);
    check_eq("alu_stall_cnt", 64'(stall_count), 64'd0);
    check_eq("alu_fwd_cnt", 64'(fwd_count), 64'd1);

    // Load-use: lw x6, consumer reads x6 (port 1) and x9 (port 0)
    drive(1'b1, 1'b1, 5'd6, 2'd1, 5'd0, 5'd0, 2'b00);
    step("lw_issue", 1'b1, 2'd0, 2'd0, RF0, RF1, 1'b0);
    drive(1'b1, 1'b1, 5'd9, 2'd0, 5'd9, 5'd6, 2'b11);
    step("lu_stall", 1'b0, 2'd0, 2'd0, RF0, RF1, 1'b1);
    check_eq("lu_stall_cnt", 64'(stall_count), 64'd1);
    step("lu_fwd", 1'b1, 2'd0, 2'd2, RF0, S1, 1'b0);
    drive(1'b1, 1'b0, 5'd0, 2'd0, 5'd9, 5'd6, 2'b11);
    step("lu_next", 1'b1, 2'd1, 2'd3, S0, S2, 1'b0);
    bubbles(3);
    check_eq("lu_fwd_cnt", 64'(fwd_count), 64'd4);

    // Youngest wins; x0 is never forwarded
    drive(1'b1, 1'b1, 5'd7, 2'd0, 5'd0, 5'd0, 2'b00);
    step("x7_old", 1'b1, 2'd0, 2'd0, RF0, RF1, 1'b0);
    drive(1'b1, 1'b1, 5'd0, 2'd0, 5'd0, 5'd0, 2'b00);
    step("x0_prod", 1'b1, 2'd0, 2'd0, RF0, RF1, 1'b0);
    drive(1'b1, 1'b1, 5'd7, 2'd0, 5'd0, 5'd0, 2'b00);
    step("x7_new", 1'b1, 2'd0, 2'd0, RF0, RF1, 1'b0);
    drive(1'b1, 1'b0, 5'd0, 2'd0, 5'd7, 5'd0, 2'b11);
    step("youngest", 1'b1, 2'd1, 2'd0, S0, RF1, 1'b0);
    bubbles(3);
    check_eq("young_fwd_cnt", 64'(fwd_count), 64'd5);

    // Hold: load x11 stays in EX while pipe_advance is low
    drive(1'b1, 1'b1, 5'd11, 2'd1, 5'd0, 5'd0, 2'b00);
    step("ld11", 1'b1, 2'd0, 2'd0, RF0, RF1, 1'b0);
    pipe_advance = 1'b0;
    drive(1'b1, 1'b1, 5'd13, 2'd0, 5'd11, 5'd0, 2'b01);
    for (int h = 0; h < 3; h++) step("hold", 1'b0, 2'd0, 2'd0, RF0, RF1, 1'b1);
    pipe_advance = 1'b1;
    step("hold_rel", 1'b0, 2'd0, 2'd0, RF0, RF1, 1'b1);
    step("hold_fwd", 1'b1, 2'd2, 2'd0, S1, RF1, 1'b0);
    check_eq("hold_stall_cnt", 64'(stall_count), 64'd5);
    bubbles(3);

    // Flush with a pending hazard: no stall, bubble enters
    drive(1'b1, 1'b1, 5'd12, 2'd1, 5'd0, 5'd0, 2'b00);
    step("ld12", 1'b1, 2'd0, 2'd0, RF0, RF1, 1'b0);
    flush = 1'b1;
    drive(1'b1, 1'b1, 5'd13, 2'd0, 5'd12, 5'd0, 2'b01);
    step("flush", 1'b0, 2'd0, 2'd0, RF0, RF1, 1'b0);
    flush = 1'b0;
    drive(1'b1, 1'b1, 5'd14, 2'd0, 5'd12, 5'd13, 2'b11);
    step("post_flush", 1'b1, 2'd2, 2'd0, S1, RF1, 1'b0);
    check_eq("flush_stall_cnt", 64'(stall_count), 64'd5);
    check_eq("flush_fwd_cnt", 64'(fwd_count), 64'd7);
    bubbles(3);

    // Counter saturation via backdoor preload, then clear
    force dut.fwd_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.fwd_count_q;
    drive(1'b1, 1'b1, 5'd14, 2'd0, 5'd0, 5'd0, 2'b00);
    step("sat_prod", 1'b1, 2'd0, 2'd0, RF0, RF1, 1'b0);
    drive(1'b1, 1'b0, 5'd0, 2'd0, 5'd14, 5'd14, 2'b11);
    step("sat_fwd", 1'b1, 2'd1, 2'd1, S0, S0, 1'b0);
    check_eq("sat_cnt", 64'(fwd_count), 64'hFFFF_FFFF);
    step("sat_fwd2", 1'b1, 2'd2, 2'd2, S1, S1, 1'b0);
    check_eq("sat_hold", 64'(fwd_count), 64'hFFFF_FFFF);
    clear_counters = 1'b1;
    step("clr_fwd", 1'b1, 2'd3, 2'd3, S2, S2, 1'b0);
    clear_counters = 1'b0;
    check_eq("clr_fwd_cnt", 64'(fwd_count), 64'd0);
    check_eq("clr_stall_cnt", 64'(stall_count), 64'd0);
    bubbles(3);

    // Asynchronous reset in the middle of a stall
    drive(1'b1, 1'b1, 5'd15, 2'd1, 5'd0, 5'd0, 2'b00);
    step("ld15", 1'b1, 2'd0, 2'd0, RF0, RF1, 1'b0);
    pipe_advance = 1'b0;
    drive(1'b1, 1'b1, 5'd16, 2'd0, 5'd15, 5'd0, 2'b01);
    step("pre_rst", 1'b0, 2'd0, 2'd0, RF0, RF1, 1'b1);
    push_exp("pre_rst2", 1'b0, 2'd0, 2'd0, RF0, RF1, 1'b1);
    #2;
    compare_exp();
    check_eq("pre_rst_cnt", 64'(stall_count), 64'd1);
    rst_n = 1'b0;
    push_exp("async_rst", 1'b1, 2'd0, 2'd0, RF0, RF1, 1'b0);
    #1;
    compare_exp();
    check_eq("async_stall_cnt", 64'(stall_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pipe_advance = 1'b1;
    step("post_rst", 1'b1, 2'd0, 2'd0, RF0, RF1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
